// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus between the fetch stage and imem.
//   imem_req    fetch request, accepted by memory on the cycle it is high
//   imem_addr   fetch address
//   imem_rvalid response valid, one or more cycles after the accepted request
//   imem_rdata  instruction word, valid with imem_rvalid
// master = fetch stage side, slave = instruction memory side.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage upstream of the decoder. Owns the PC,
// keeps one request outstanding to instruction memory and fills the IF/ID
// register read by the decoder.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   stall            decoder cannot accept; IF/ID holds
//   redirect         taken branch/jump, load redirect_pc (word aligned)
//   redirect_pc      redirect target
//   imem             instruction memory bus (master side)
//   valid_out        IF/ID holds a live instruction
//   instruction_out  IF/ID instruction (NOP_INSTR when not valid)
//   pc_out           PC of instruction_out
//   pc_plus4_out     pc_out + 4, link value for JAL/JALR
//
// state | meaning
// IDLE  | first cycle after reset, no request
// REQ   | imem_req high, request for pc accepted this cycle
// WAIT  | request outstanding, waiting for imem_rvalid
// HOLD  | response captured in hold_buf, waiting for IF/ID to free up
// DROP  | stale request outstanding after a redirect, response discarded
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0100_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master imem,
    output logic          valid_out,
    output logic [31:0]   instruction_out,
    output logic [31:0]   pc_out,
    output logic [31:0]   pc_plus4_out
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic        imem_req_q;
    logic        if_free;

    assign if_free        = !valid_out || !stall;
    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc;
    assign pc_plus4_out   = pc_out + 32'd4;

    // imem_req is registered: it is set on every transition into REQ.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            hold_buf        <= '0;
            imem_req_q      <= 1'b0;
            valid_out       <= 1'b0;
            instruction_out <= NOP_INSTR;
            pc_out          <= '0;
        end else begin
            imem_req_q <= 1'b0;

            // Decoder consumes the entry; a load below overrides this.
            if (valid_out && !stall) begin
                valid_out       <= 1'b0;
                instruction_out <= NOP_INSTR;
            end

            if (redirect) begin
                pc              <= {redirect_pc[31:2], 2'b00};
                valid_out       <= 1'b0;
                instruction_out <= NOP_INSTR;
                hold_buf        <= '0;
                case (state)
                    // A response landing this very cycle retires the
                    // outstanding request, so nothing is left to drain.
                    WAIT, DROP: begin
                        if (imem.imem_rvalid) begin
                            state      <= REQ;
                            imem_req_q <= 1'b1;
                        end else begin
                            state <= DROP;
                        end
                    end
                    // The request issued this cycle is already in flight.
                    REQ: state <= DROP;
                    default: begin
                        state      <= REQ;
                        imem_req_q <= 1'b1;
                    end
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        state      <= REQ;
                        imem_req_q <= 1'b1;
                    end
                    REQ: state <= WAIT;
                    WAIT: begin
                        if (imem.imem_rvalid) begin
                            if (if_free) begin
                                valid_out       <= 1'b1;
                                instruction_out <= imem.imem_rdata;
                                pc_out          <= pc;
                                pc              <= pc + 32'd4;
                                state           <= REQ;
                                imem_req_q      <= 1'b1;
                            end else begin
                                hold_buf <= imem.imem_rdata;
                                state    <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            valid_out       <= 1'b1;
                            instruction_out <= hold_buf;
                            pc_out          <= pc;
                            pc              <= pc + 32'd4;
                            state           <= REQ;
                            imem_req_q      <= 1'b1;
                        end
                    end
                    DROP: begin
                        if (imem.imem_rvalid) begin
                            state      <= REQ;
                            imem_req_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a small latency-
// programmable instruction memory model driven from the tick task.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid_out;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;

    int total = 0;
    int bad = 0;

    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          proto_err = 0;
    logic        late_ok = 1'b0;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem            (imem.master),
        .valid_out       (valid_out),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .pc_plus4_out    (pc_plus4_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0050_0093;
        return ~a;
    endfunction

    // Advance one cycle, then update the memory model for the new cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        imem.imem_rvalid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = mem_word(mem_addr);
            end
        end
        if (imem.imem_req) begin
            mem_cnt  = mem_lat;
            mem_addr = imem.imem_addr;
        end
        if (imem.imem_rvalid && imem.imem_req && !late_ok) proto_err++;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h want=0", valid_out); end
        total++; if (instruction_out !== NOP) begin bad++; $display("FAIL rst_instr got=%h want=%h", instruction_out, NOP); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc_out got=%h want=0", pc_out); end
        total++; if (pc_plus4_out !== 32'h4) begin bad++; $display("FAIL rst_pc_plus4 got=%h want=4", pc_plus4_out); end
        total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h want=0", imem.imem_req); end
        total++; if (imem.imem_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr got=%h want=%h", imem.imem_addr, RESET_PC); end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        tick();
        total++; if (imem.imem_req !== 1'b1) begin bad++; $display("FAIL f1_req got=%h want=1", imem.imem_req); end
        total++; if (imem.imem_addr !== RESET_PC) begin bad++; $display("FAIL f1_addr got=%h want=%h", imem.imem_addr, RESET_PC); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL f1_valid got=%h want=0", valid_out); end
        tick();
        total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL f1_wait_req got=%h want=0", imem.imem_req); end
        tick();
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL f1_out_valid got=%h want=1", valid_out); end
        total++; if (instruction_out !== 32'h0050_0093) begin bad++; $display("FAIL f1_out_instr got=%h want=00500093", instruction_out); end
        total++; if (pc_out !== 32'h0100_0000) begin bad++; $display("FAIL f1_out_pc got=%h want=01000000", pc_out); end
        total++; if (pc_plus4_out !== 32'h0100_0004) begin bad++; $display("FAIL f1_out_pc4 got=%h want=01000004", pc_plus4_out); end
        total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0100_0004) begin bad++; $display("FAIL f2_req got=%h/%h want=1/01000004", imem.imem_req, imem.imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req cyc=%0d got=%h want=0", i, imem.imem_req); end
            total++; if (valid_out !== 1'b1 || instruction_out !== 32'h0050_0093 || pc_out !== RESET_PC) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%h/%h/%h want=1/00500093/%h", i, valid_out, instruction_out, pc_out, RESET_PC);
            end
        end
        stall = 1'b0;
        tick();
        total++; if (valid_out !== 1'b1 || instruction_out !== 32'hFEFF_FFFB) begin bad++; $display("FAIL stall_i2 got=%h/%h want=1/fefffffb", valid_out, instruction_out); end
        total++; if (pc_out !== 32'h0100_0004 || pc_plus4_out !== 32'h0100_0008) begin bad++; $display("FAIL stall_i2_pc got=%h/%h want=01000004/01000008", pc_out, pc_plus4_out); end
        total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0100_0008) begin bad++; $display("FAIL stall_i3_req got=%h/%h want=1/01000008", imem.imem_req, imem.imem_addr); end
        tick();
        total++; if (valid_out !== 1'b0 || instruction_out !== NOP) begin bad++; $display("FAIL stall_consume got=%h/%h want=0/%h", valid_out, instruction_out, NOP); end
        mem_lat = 3;
        tick();
        total++; if (valid_out !== 1'b1 || instruction_out !== 32'hFEFF_FFF7 || pc_out !== 32'h0100_0008) begin
            bad++; $display("FAIL stall_i3 got=%h/%h/%h want=1/fefffff7/01000008", valid_out, instruction_out, pc_out);
        end
        total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0100_000C) begin bad++; $display("FAIL stall_i4_req got=%h/%h want=1/0100000c", imem.imem_req, imem.imem_addr); end
    endtask

    task automatic test_redirect_drop();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0100_0043;
        tick();
        redirect = 1'b0;
        total++; if (imem.imem_req !== 1'b0 || imem.imem_addr !== 32'h0100_0040) begin bad++; $display("FAIL drop_pc got=%h/%h want=0/01000040", imem.imem_req, imem.imem_addr); end
        tick();
        total++; if (valid_out !== 1'b0 || imem.imem_req !== 1'b0) begin bad++; $display("FAIL drop_stale got=%h/%h want=0/0", valid_out, imem.imem_req); end
        tick();
        total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0100_0040 || valid_out !== 1'b0) begin
            bad++; $display("FAIL drop_newreq got=%h/%h/%h want=1/01000040/0", imem.imem_req, imem.imem_addr, valid_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (valid_out !== 1'b0 || imem.imem_req !== 1'b0) begin bad++; $display("FAIL drop_wait cyc=%0d got=%h/%h want=0/0", i, valid_out, imem.imem_req); end
        end
        tick();
        total++; if (valid_out !== 1'b1 || instruction_out !== 32'hFEFF_FFBF || pc_out !== 32'h0100_0040) begin
            bad++; $display("FAIL drop_word got=%h/%h/%h want=1/feffffbf/01000040", valid_out, instruction_out, pc_out);
        end
    endtask

    task automatic test_redirect_stall();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0200_0000;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        total++; if (valid_out !== 1'b0 || instruction_out !== NOP) begin bad++; $display("FAIL rs_flush got=%h/%h want=0/%h", valid_out, instruction_out, NOP); end
        total++; if (imem.imem_addr !== 32'h0200_0000 || imem.imem_req !== 1'b0) begin bad++; $display("FAIL rs_pc got=%h/%h want=02000000/0", imem.imem_addr, imem.imem_req); end
        tick();
        tick();
        mem_lat = 1;
        tick();
        total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0200_0000) begin bad++; $display("FAIL rs_req got=%h/%h want=1/02000000", imem.imem_req, imem.imem_addr); end
        tick();
        tick();
        total++; if (valid_out !== 1'b1 || instruction_out !== 32'hFDFF_FFFF || pc_out !== 32'h0200_0000) begin
            bad++; $display("FAIL rs_word got=%h/%h/%h want=1/fdffffff/02000000", valid_out, instruction_out, pc_out);
        end
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        total++; if (imem.imem_addr !== 32'hFFFF_FFFC || valid_out !== 1'b0) begin bad++; $display("FAIL wrap_redir got=%h/%h want=fffffffc/0", imem.imem_addr, valid_out); end
        tick();
        total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%h/%h want=1/fffffffc", imem.imem_req, imem.imem_addr); end
        tick();
        mem_lat = 3;
        tick();
        total++; if (valid_out !== 1'b1 || pc_out !== 32'hFFFF_FFFC || instruction_out !== 32'h0000_0003) begin
            bad++; $display("FAIL wrap_word got=%h/%h/%h want=1/fffffffc/00000003", valid_out, pc_out, instruction_out);
        end
        total++; if (pc_plus4_out !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h want=0", pc_plus4_out); end
        total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h/%h want=1/0", imem.imem_req, imem.imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        reset   = 1'b1;
        late_ok = 1'b1;
        tick();
        total++; if (valid_out !== 1'b0 || instruction_out !== NOP || pc_out !== 32'h0) begin
            bad++; $display("FAIL mid_rst_out got=%h/%h/%h want=0/%h/0", valid_out, instruction_out, pc_out, NOP);
        end
        total++; if (imem.imem_req !== 1'b0 || imem.imem_addr !== RESET_PC) begin bad++; $display("FAIL mid_rst_pc got=%h/%h want=0/%h", imem.imem_req, imem.imem_addr, RESET_PC); end
        reset = 1'b0;
        tick();
        late_ok = 1'b0;
        total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC) begin bad++; $display("FAIL mid_rst_req got=%h/%h want=1/%h", imem.imem_req, imem.imem_addr, RESET_PC); end
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mid_rst_late got=%h want=0", valid_out); end
        tick();
        tick();
        tick();
        total++; if (valid_out !== 1'b1 || instruction_out !== 32'h0050_0093 || pc_out !== RESET_PC) begin
            bad++; $display("FAIL mid_rst_word got=%h/%h/%h want=1/00500093/%h", valid_out, instruction_out, pc_out, RESET_PC);
        end
    endtask

    task automatic test_protocol();
        total++; if (proto_err !== 0) begin bad++; $display("FAIL rvalid_during_req got=%0d want=0", proto_err); end
    endtask

    initial begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_drop();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_wait();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
